// File: rtl/ahb_apb_bridge.sv
// AHB-Lite to APB bridge: AHB slave front end, APB setup/enable controller and
// read-data pass-through for three peripherals at a fixed address map.
module ahb_apb_bridge (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hwrite,
    input  logic        hready_in,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [31:0] pr_data,
    output logic        hready_out,
    output logic [1:0]  hresp,
    output logic [31:0] hr_data,
    output logic        p_write,
    output logic        p_enable,
    output logic [2:0]  p_selx,
    output logic [31:0] paddr,
    output logic [31:0] pwdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_READ,
        ST_WRITE,
        ST_WRITEP,
        ST_RENABLE,
        ST_WENABLE,
        ST_WENABLEP
    } state_e;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    function automatic logic [2:0] sel_decode(input logic [31:0] addr);
        if (addr >= 32'h8000_0000 && addr < 32'h8400_0000)
            return 3'b001;
        else if (addr >= 32'h8400_0000 && addr < 32'h8800_0000)
            return 3'b010;
        else if (addr >= 32'h8800_0000 && addr < 32'h8C00_0000)
            return 3'b100;
        else
            return 3'b000;
    endfunction

    state_e      state_q, state_d;
    logic        hready_out_q, hready_out_d;
    logic [2:0]  p_selx_q, p_selx_d;
    logic        p_enable_q, p_enable_d;
    logic        p_write_q, p_write_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [31:0] haddr1_q, haddr1_d;
    logic [31:0] haddr2_q, haddr2_d;
    logic [31:0] hwdata1_q, hwdata1_d;
    logic        hwrite_reg_q, hwrite_reg_d;

    logic        valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    always_comb begin
        valid = hready_in
                && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)
                && haddr >= 32'h8000_0000 && haddr < 32'h8C00_0000;
    end

    // A write issued from WENABLEP belongs to the pipelined second transfer,
    // so it takes the older address/data pair; otherwise data is live on the bus.
    always_comb begin
        wr_addr = (state_q == ST_WENABLEP) ? haddr2_q  : haddr1_q;
        wr_data = (state_q == ST_WENABLEP) ? hwdata1_q : hwdata;
    end

    always_comb begin
        haddr1_d     = haddr1_q;
        haddr2_d     = haddr2_q;
        hwdata1_d    = hwdata1_q;
        hwrite_reg_d = hwrite_reg_q;
        if (hready_in) begin
            haddr1_d     = haddr;
            haddr2_d     = haddr1_q;
            hwdata1_d    = hwdata;
            hwrite_reg_d = hwrite;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (valid && hwrite)
                    state_d = ST_WWAIT;
                else if (valid)
                    state_d = ST_READ;
            end
            ST_WWAIT:  state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:   state_d = ST_RENABLE;
            ST_WRITE:  state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP: state_d = ST_WENABLEP;
            ST_RENABLE, ST_WENABLE: begin
                if (valid && !hwrite)
                    state_d = ST_READ;
                else if (valid)
                    state_d = ST_WWAIT;
                else
                    state_d = ST_IDLE;
            end
            ST_WENABLEP: begin
                if (!hwrite_reg_q)
                    state_d = ST_READ;
                else if (valid)
                    state_d = ST_WRITEP;
                else
                    state_d = ST_WRITE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // APB outputs are a function of the state being entered, so they change
    // on the same edge as the state register.
    always_comb begin
        hready_out_d = hready_out_q;
        p_selx_d     = p_selx_q;
        p_enable_d   = p_enable_q;
        p_write_d    = p_write_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        case (state_d)
            ST_IDLE, ST_WWAIT: begin
                p_selx_d     = 3'b000;
                p_enable_d   = 1'b0;
                hready_out_d = 1'b1;
            end
            ST_READ: begin
                p_selx_d     = sel_decode(haddr);
                paddr_d      = haddr;
                p_write_d    = 1'b0;
                p_enable_d   = 1'b0;
                hready_out_d = 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
                p_selx_d     = sel_decode(wr_addr);
                paddr_d      = wr_addr;
                pwdata_d     = wr_data;
                p_write_d    = 1'b1;
                p_enable_d   = 1'b0;
                hready_out_d = (state_d == ST_WRITE);
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                p_enable_d   = 1'b1;
                hready_out_d = 1'b1;
            end
            default: begin
                p_selx_d     = 3'b000;
                p_enable_d   = 1'b0;
                hready_out_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= ST_IDLE;
            hready_out_q <= 1'b1;
            p_selx_q     <= 3'b000;
            p_enable_q   <= 1'b0;
            p_write_q    <= 1'b0;
            paddr_q      <= 32'h0;
            pwdata_q     <= 32'h0;
            haddr1_q     <= 32'h0;
            haddr2_q     <= 32'h0;
            hwdata1_q    <= 32'h0;
            hwrite_reg_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hready_out_q <= hready_out_d;
            p_selx_q     <= p_selx_d;
            p_enable_q   <= p_enable_d;
            p_write_q    <= p_write_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            haddr1_q     <= haddr1_d;
            haddr2_q     <= haddr2_d;
            hwdata1_q    <= hwdata1_d;
            hwrite_reg_q <= hwrite_reg_d;
        end
    end

    assign hready_out = hready_out_q;
    assign p_selx     = p_selx_q;
    assign p_enable   = p_enable_q;
    assign p_write    = p_write_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign hresp      = 2'b00;
    assign hr_data    = pr_data;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: a cycle-by-cycle vector table plus
// hand-written reset sequences.
module tb_ahb_apb_bridge;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hwrite;
    logic        hready_in;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] pr_data;
    logic        hready_out;
    logic [1:0]  hresp;
    logic [31:0] hr_data;
    logic        p_write;
    logic        p_enable;
    logic [2:0]  p_selx;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    ahb_apb_bridge dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .hwrite     (hwrite),
        .hready_in  (hready_in),
        .htrans     (htrans),
        .haddr      (haddr),
        .hwdata     (hwdata),
        .pr_data    (pr_data),
        .hready_out (hready_out),
        .hresp      (hresp),
        .hr_data    (hr_data),
        .p_write    (p_write),
        .p_enable   (p_enable),
        .p_selx     (p_selx),
        .paddr      (paddr),
        .pwdata     (pwdata)
    );

    always #5 hclk = ~hclk;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NS   = 2'b10;

    typedef struct {
        logic        hri;
        logic        hw;
        logic [1:0]  tr;
        logic [31:0] ad;
        logic [31:0] wd;
        logic        rdy;
        logic [2:0]  sel;
        logic        en;
        logic        pw;
        logic [31:0] pa;
        logic [31:0] pd;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic hri, input logic hw, input logic [1:0] tr,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input logic rdy, input logic [2:0] sel, input logic en,
                       input logic pw, input logic [31:0] pa, input logic [31:0] pd);
        vec_t v;
        v.hri = hri; v.hw = hw; v.tr = tr; v.ad = ad; v.wd = wd;
        v.rdy = rdy; v.sel = sel; v.en = en; v.pw = pw; v.pa = pa; v.pd = pd;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic hri, input logic hw, input logic [1:0] tr,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input logic [31:0] prd);
        hready_in = hri; hwrite = hw; htrans = tr; haddr = ad; hwdata = wd; pr_data = prd;
    endtask

    // Compares every output against expectations; hr_data must mirror pr_data and hresp is OKAY.
    task automatic check(input string name, input logic rdy, input logic [2:0] sel,
                         input logic en, input logic pw, input logic [31:0] pa,
                         input logic [31:0] pd);
        logic [103:0] act, exp;
        act = {hready_out, p_selx, p_enable, p_write, paddr, pwdata, hresp, hr_data};
        exp = {rdy, sel, en, pw, pa, pd, 2'b00, pr_data};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got rdy=%b sel=%b en=%b pw=%b pa=%h pd=%h resp=%b hr=%h, want rdy=%b sel=%b en=%b pw=%b pa=%h pd=%h resp=00 hr=%h",
                     name, hready_out, p_selx, p_enable, p_write, paddr, pwdata, hresp, hr_data,
                     rdy, sel, en, pw, pa, pd, pr_data);
        end
    endtask

    initial begin
        // Ignored transfers: out of range, IDLE, BUSY, boundaries
        add(1,0,T_NS,  32'h9000_0000,0,            1,3'b000,0,0,32'h0,0);
        add(1,0,T_IDLE,32'h8000_0000,0,            1,3'b000,0,0,32'h0,0);
        add(1,0,T_BUSY,32'h8000_0000,0,            1,3'b000,0,0,32'h0,0);
        add(1,0,T_NS,  32'h8C00_0000,0,            1,3'b000,0,0,32'h0,0);
        add(1,0,T_NS,  32'h7FFF_FFFC,0,            1,3'b000,0,0,32'h0,0);
        // Single read
        add(1,0,T_NS,  32'h8000_0000,0,            0,3'b001,0,0,32'h8000_0000,0);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b001,1,0,32'h8000_0000,0);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b000,0,0,32'h8000_0000,0);
        // Single write
        add(1,1,T_NS,  32'h8400_0010,0,            1,3'b000,0,0,32'h8000_0000,0);
        add(1,0,T_IDLE,32'h0,32'hA5A5_0001,        1,3'b010,0,1,32'h8400_0010,32'hA5A5_0001);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b010,1,1,32'h8400_0010,32'hA5A5_0001);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b000,0,1,32'h8400_0010,32'hA5A5_0001);
        // Back-to-back writes
        add(1,1,T_NS,  32'h8800_0000,0,            1,3'b000,0,1,32'h8400_0010,32'hA5A5_0001);
        add(1,1,T_NS,  32'h8800_0004,32'h11,       0,3'b100,0,1,32'h8800_0000,32'h11);
        add(1,1,T_IDLE,32'h0,32'h22,               1,3'b100,1,1,32'h8800_0000,32'h11);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b100,0,1,32'h8800_0004,32'h22);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b100,1,1,32'h8800_0004,32'h22);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b000,0,1,32'h8800_0004,32'h22);
        // Read at top of range, then read and write issued from RENABLE
        add(1,0,T_NS,  32'h8BFF_FFFC,0,            0,3'b100,0,0,32'h8BFF_FFFC,32'h22);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b100,1,0,32'h8BFF_FFFC,32'h22);
        add(1,0,T_NS,  32'h8400_0008,0,            0,3'b010,0,0,32'h8400_0008,32'h22);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b010,1,0,32'h8400_0008,32'h22);
        add(1,1,T_NS,  32'h8000_0004,0,            1,3'b000,0,0,32'h8400_0008,32'h22);
        add(1,0,T_IDLE,32'h0,32'h33,               1,3'b001,0,1,32'h8000_0004,32'h33);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b001,1,1,32'h8000_0004,32'h33);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b000,0,1,32'h8000_0004,32'h33);
        // Write followed by read: WENABLEP -> READ
        add(1,1,T_NS,  32'h8000_0000,0,            1,3'b000,0,1,32'h8000_0004,32'h33);
        add(1,0,T_NS,  32'h8400_0000,32'h44,       0,3'b001,0,1,32'h8000_0000,32'h44);
        add(1,0,T_NS,  32'h8400_0000,0,            1,3'b001,1,1,32'h8000_0000,32'h44);
        add(1,0,T_NS,  32'h8400_0000,0,            0,3'b010,0,0,32'h8400_0000,32'h44);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b010,1,0,32'h8400_0000,32'h44);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b000,0,0,32'h8400_0000,32'h44);
        // hready_in low masks an otherwise valid transfer
        add(0,0,T_NS,  32'h8000_0000,0,            1,3'b000,0,0,32'h8400_0000,32'h44);
        // Three pipelined writes: WENABLEP -> WRITEP -> WENABLEP -> WRITE
        add(1,1,T_NS,  32'h8800_0008,0,            1,3'b000,0,0,32'h8400_0000,32'h44);
        add(1,1,T_NS,  32'h8800_000C,32'h55,       0,3'b100,0,1,32'h8800_0008,32'h55);
        add(1,1,T_NS,  32'h8400_0004,32'h66,       1,3'b100,1,1,32'h8800_0008,32'h55);
        add(1,1,T_NS,  32'h8400_0004,32'h77,       0,3'b100,0,1,32'h8800_000C,32'h66);
        add(1,1,T_IDLE,32'h0,32'h88,               1,3'b100,1,1,32'h8800_000C,32'h66);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b010,0,1,32'h8400_0004,32'h88);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b010,1,1,32'h8400_0004,32'h88);
        add(1,0,T_IDLE,32'h0,0,                    1,3'b000,0,1,32'h8400_0004,32'h88);

        // Reset state
        hresetn = 1'b0;
        drive(1, 0, T_IDLE, 32'h0, 32'h0, 32'h1234_5678);
        repeat (2) @(posedge hclk);
        #1 check("reset_held", 1, 3'b000, 0, 0, 32'h0, 32'h0);
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1 check("reset_release", 1, 3'b000, 0, 0, 32'h0, 32'h0);

        foreach (vecs[i]) begin
            @(negedge hclk);
            drive(vecs[i].hri, vecs[i].hw, vecs[i].tr, vecs[i].ad, vecs[i].wd,
                  32'hD000_0000 + 32'(i));
            @(posedge hclk);
            #1 check($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].sel, vecs[i].en,
                     vecs[i].pw, vecs[i].pa, vecs[i].pd);
        end

        // Reset asserted while in READ aborts without a clock edge
        @(negedge hclk);
        drive(1, 0, T_NS, 32'h8800_0000, 32'h0, 32'hCAFE_0001);
        @(posedge hclk);
        #1 check("mid_read", 0, 3'b100, 0, 0, 32'h8800_0000, 32'h88);
        #2 hresetn = 1'b0;
        #1 check("mid_reset_async", 1, 3'b000, 0, 0, 32'h0, 32'h0);
        @(negedge hclk);
        drive(1, 0, T_IDLE, 32'h0, 32'h0, 32'hCAFE_0002);
        hresetn = 1'b1;
        @(posedge hclk);
        #1 check("after_reset_idle", 1, 3'b000, 0, 0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
